// File: rtl/sequential_to_simultaneous_reg_if.sv
// rtl/sequential_to_simultaneous_reg_if.sv - serial sample in / parallel word out bundle
interface sequential_to_simultaneous_reg_if #(
  parameter int BIT_WIDTH = 2,
  parameter int SHIFT_LEN = 1
);
  logic                           in_ctr_Srst;
  logic                           in_ctr_en;
  logic [BIT_WIDTH-1:0]           in;
  logic [BIT_WIDTH*SHIFT_LEN-1:0] out;

  modport master (
    output in_ctr_Srst,
    output in_ctr_en,
    output in,
    input  out
  );

  modport slave (
    input  in_ctr_Srst,
    input  in_ctr_en,
    input  in,
    output out
  );
endinterface

// File: rtl/sequential_to_simultaneous_reg.sv
// rtl/sequential_to_simultaneous_reg.sv - serial-in / parallel-out shift register with input delay pipeline
module sequential_to_simultaneous_reg #(
  parameter string OUTTER_NAME  = "",
  parameter string MODULE_NAME  = "",
  parameter int    DIRECTION    = 1,
  parameter int    SHIFT_LEN    = 1,
  parameter int    BIT_WIDTH    = 2,
  parameter int    CLK_DISTANCE = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  sequential_to_simultaneous_reg_if.slave bus
);

  logic                 chain_en;
  logic [BIT_WIDTH-1:0] chain_data;
  logic [BIT_WIDTH-1:0] slot [SHIFT_LEN];

  // Data and enable travel together so the delayed enable always qualifies its own sample.
  if (CLK_DISTANCE <= 1) begin : g_no_pipe
    assign chain_en   = bus.in_ctr_en;
    assign chain_data = bus.in;
  end else begin : g_pipe
    localparam int STAGES = CLK_DISTANCE - 1;

    logic                 en_pipe   [STAGES];
    logic [BIT_WIDTH-1:0] data_pipe [STAGES];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < STAGES; i++) begin
          en_pipe[i]   <= 1'b0;
          data_pipe[i] <= '0;
        end
      end else if (bus.in_ctr_Srst) begin
        for (int i = 0; i < STAGES; i++) begin
          en_pipe[i]   <= 1'b0;
          data_pipe[i] <= '0;
        end
      end else begin
        en_pipe[0]   <= bus.in_ctr_en;
        data_pipe[0] <= bus.in;
        for (int i = 1; i < STAGES; i++) begin
          en_pipe[i]   <= en_pipe[i-1];
          data_pipe[i] <= data_pipe[i-1];
        end
      end
    end

    assign chain_en   = en_pipe[STAGES-1];
    assign chain_data = data_pipe[STAGES-1];
  end

  // With SHIFT_LEN=1 both directions collapse to loading slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SHIFT_LEN; k++) slot[k] <= '0;
    end else if (bus.in_ctr_Srst) begin
      for (int k = 0; k < SHIFT_LEN; k++) slot[k] <= '0;
    end else if (chain_en) begin
      if (DIRECTION > 0) begin
        for (int k = 1; k < SHIFT_LEN; k++) slot[k] <= slot[k-1];
        slot[0] <= chain_data;
      end else begin
        for (int k = 0; k < SHIFT_LEN - 1; k++) slot[k] <= slot[k+1];
        slot[SHIFT_LEN-1] <= chain_data;
      end
    end
  end

  for (genvar k = 0; k < SHIFT_LEN; k++) begin : g_out
    assign bus.out[BIT_WIDTH*k +: BIT_WIDTH] = slot[k];
  end

endmodule

// File: tb/tb_sequential_to_simultaneous_reg.sv
// tb/tb_sequential_to_simultaneous_reg.sv - table, corner-case and random checks against a history model
module tb_sequential_to_simultaneous_reg;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sequential_to_simultaneous_reg_if #(.BIT_WIDTH(2), .SHIFT_LEN(4)) f_if ();
  sequential_to_simultaneous_reg_if #(.BIT_WIDTH(2), .SHIFT_LEN(4)) b_if ();
  sequential_to_simultaneous_reg_if #(.BIT_WIDTH(2), .SHIFT_LEN(4)) p_if ();
  sequential_to_simultaneous_reg_if #(.BIT_WIDTH(2), .SHIFT_LEN(1)) s_if ();

  sequential_to_simultaneous_reg #(.MODULE_NAME("fwd"), .DIRECTION(1), .SHIFT_LEN(4),
    .BIT_WIDTH(2), .CLK_DISTANCE(1)) u_fwd (.clk(clk), .rst(rst), .bus(f_if));
  sequential_to_simultaneous_reg #(.MODULE_NAME("bwd"), .DIRECTION(0), .SHIFT_LEN(4),
    .BIT_WIDTH(2), .CLK_DISTANCE(1)) u_bwd (.clk(clk), .rst(rst), .bus(b_if));
  sequential_to_simultaneous_reg #(.MODULE_NAME("pipe"), .DIRECTION(1), .SHIFT_LEN(4),
    .BIT_WIDTH(2), .CLK_DISTANCE(3)) u_pipe (.clk(clk), .rst(rst), .bus(p_if));
  sequential_to_simultaneous_reg #(.MODULE_NAME("single"), .DIRECTION(-1), .SHIFT_LEN(1),
    .BIT_WIDTH(2), .CLK_DISTANCE(2)) u_single (.clk(clk), .rst(rst), .bus(s_if));

  typedef struct {
    logic       en;
    logic [1:0] data;
  } hist_t;

  // Edges seen since the last clear (reset or Srst); the clearing edge itself is not kept.
  hist_t hist[$];

  typedef struct {
    logic       srst;
    logic       en;
    logic [1:0] data;
    logic [7:0] exp_fwd;
    logic [7:0] exp_bwd;
  } vec_t;

  function automatic logic [7:0] model_out(int len, int dir, int cd);
    logic [1:0] samples[$];
    logic [7:0] word;
    int         usable;
    int         slot_idx;
    word   = '0;
    usable = hist.size() - (cd - 1);
    for (int i = 0; i < usable; i++)
      if (hist[i].en) samples.push_back(hist[i].data);
    for (int k = 0; k < len && k < samples.size(); k++) begin
      slot_idx = (dir > 0) ? k : len - 1 - k;
      word[slot_idx*2 +: 2] = samples[samples.size()-1-k];
    end
    return word;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic srst, input logic en, input logic [1:0] data);
    f_if.in_ctr_Srst = srst; f_if.in_ctr_en = en; f_if.in = data;
    b_if.in_ctr_Srst = srst; b_if.in_ctr_en = en; b_if.in = data;
    p_if.in_ctr_Srst = srst; p_if.in_ctr_en = en; p_if.in = data;
    s_if.in_ctr_Srst = srst; s_if.in_ctr_en = en; s_if.in = data;
  endtask

  task automatic check_model();
    check("fwd_model",    f_if.out,          model_out(4, 1, 1));
    check("bwd_model",    b_if.out,          model_out(4, 0, 1));
    check("pipe_model",   p_if.out,          model_out(4, 1, 3));
    check("single_model", {6'b0, s_if.out},  model_out(1, 0, 2));
  endtask

  task automatic step(input logic srst, input logic en, input logic [1:0] data);
    hist_t h;
    drive(srst, en, data);
    @(posedge clk);
    if (srst) hist.delete();
    else begin
      h.en   = en;
      h.data = data;
      hist.push_back(h);
    end
    #1;
    check_model();
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #2;
    hist.delete();
    check("async_rst_fwd",  f_if.out, 8'h00);
    check("async_rst_pipe", p_if.out, 8'h00);
    rst = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{1'b0, 1'b1, 2'd1, 8'h01, 8'h40};
    vecs[1]  = '{1'b0, 1'b1, 2'd2, 8'h06, 8'h90};
    vecs[2]  = '{1'b0, 1'b1, 2'd3, 8'h1B, 8'hE4};
    vecs[3]  = '{1'b0, 1'b1, 2'd0, 8'h6C, 8'h39};
    vecs[4]  = '{1'b1, 1'b1, 2'd2, 8'h00, 8'h00};
    vecs[5]  = '{1'b0, 1'b1, 2'd2, 8'h02, 8'h80};
    vecs[6]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 2'd1, 8'h01, 8'h40};
    vecs[8]  = '{1'b0, 1'b0, 2'd3, 8'h01, 8'h40};
    vecs[9]  = '{1'b0, 1'b0, 2'd3, 8'h01, 8'h40};
    vecs[10] = '{1'b0, 1'b0, 2'd3, 8'h01, 8'h40};
    vecs[11] = '{1'b0, 1'b1, 2'd2, 8'h06, 8'h90};

    // Reset held with live stimulus must keep every word at zero.
    rst = 1'b1;
    drive(1'b0, 1'b1, 2'd3);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_fwd",    f_if.out,         8'h00);
    check("rst_hold_bwd",    b_if.out,         8'h00);
    check("rst_hold_pipe",   p_if.out,         8'h00);
    check("rst_hold_single", {6'b0, s_if.out}, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 2'd3);
      check("idle_fwd", f_if.out, 8'h00);
    end

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].srst, vecs[i].en, vecs[i].data);
      check($sformatf("vec%0d_fwd", i), f_if.out, vecs[i].exp_fwd);
      check($sformatf("vec%0d_bwd", i), b_if.out, vecs[i].exp_bwd);
    end

    // CLK_DISTANCE=3: a lone pulse reaches slot 0 only after the second following edge.
    step(1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b1, 2'd3);
    check("cd3_edge_t",  {6'b0, p_if.out[1:0]}, 8'h00);
    step(1'b0, 1'b0, 2'd0);
    check("cd3_edge_t1", {6'b0, p_if.out[1:0]}, 8'h00);
    step(1'b0, 1'b0, 2'd0);
    check("cd3_edge_t2", {6'b0, p_if.out[1:0]}, 8'h03);

    // Five samples into four slots: the first one falls off the top.
    step(1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b1, 2'd1);
    step(1'b0, 1'b1, 2'd2);
    step(1'b0, 1'b1, 2'd3);
    step(1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b1, 2'd2);
    check("overflow_fwd", f_if.out, 8'hB2);
    check("overflow_bwd", b_if.out, 8'h8E);

    // Mid-stream async reset discards partial words.
    step(1'b0, 1'b1, 2'd1);
    async_reset();
    step(1'b0, 1'b0, 2'd0);
    check("post_rst_fwd", f_if.out, 8'h00);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) async_reset();
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
